// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// State encoding and operand magnitude function.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Widest operand the magnitude helper handles; callers zero-extend
    // into this width and truncate the result back to their own width.
    localparam int MAG_MAX_W = 64;

    // Two's complement negation modulo 2^MAG_MAX_W; after truncation to
    // the caller's width this is the unsigned magnitude, so -2^(W-1)
    // comes back as 2^(W-1) which still fits in W unsigned bits.
    function automatic logic [MAG_MAX_W-1:0] mag_of(
        input logic [MAG_MAX_W-1:0] val,
        input logic                 neg
    );
        return neg ? -val : val;
    endfunction

endpackage

// File: rtl/seq_mult_dp.sv
// Datapath: operand capture, shift-add accumulation and final sign fix.
// Control (load/step) comes from the handshake FSM in seq_mult_hs.
module seq_mult_dp #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               last,
    output logic [2*WIDTH-1:0] product
);
    import seq_mult_pkg::*;

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic               neg;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] prod_q;
    logic [CNT_W-1:0]   cnt;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    assign a_neg = is_signed & a[WIDTH-1];
    assign b_neg = is_signed & b[WIDTH-1];
    assign a_mag = WIDTH'(mag_of(MAG_MAX_W'(a), a_neg));
    assign b_mag = WIDTH'(mag_of(MAG_MAX_W'(b), b_neg));

    assign addend   = {{WIDTH{1'b0}}, mcand} << cnt;
    assign acc_next = mplier[0] ? acc + addend : acc;
    assign last     = (cnt == CNT_W'(WIDTH - 1));
    assign product  = prod_q;

    // Capture magnitudes on accept, then one partial product per step;
    // the last step also writes the sign-corrected product.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
            prod_q <= '0;
        end else if (load) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            neg    <= a_neg ^ b_neg;
            acc    <= '0;
            cnt    <= '0;
        end else if (step) begin
            acc    <= acc_next;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
            if (last) begin
                prod_q <= neg ? -acc_next : acc_next;
            end
        end
    end

endmodule

// File: rtl/seq_mult_hs.sv
// Sequential WIDTH x WIDTH multiplier with ready/valid on both sides.
// One operation in flight; handshake outputs decode the state register.
module seq_mult_hs #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);
    import seq_mult_pkg::*;

    state_t state_q;
    state_t state_d;
    logic   load;
    logic   step;
    logic   last;

    // State register; reset aborts any operation in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath strobes.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN) || (state_q == DONE);

    seq_mult_dp #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_dp (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .step      (step),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .last      (last),
        .product   (product)
    );

endmodule

// File: tb/tb_seq_mult_hs.sv
// Bench for seq_mult_hs: directed and random ops at WIDTH 8, 4 and 16
// checked against an integer-arithmetic reference model.
module tb_seq_mult_hs;

    logic        clk;
    logic        rst;

    logic        iv4, ir4, s4, ov4, or4, bz4;
    logic [3:0]  a4, b4;
    logic [7:0]  p4;

    logic        iv8, ir8, s8, ov8, or8, bz8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    logic        iv16, ir16, s16, ov16, or16, bz16;
    logic [15:0] a16, b16;
    logic [31:0] p16;

    int checks;
    int errors;

    seq_mult_hs #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4), .is_signed(s4), .out_valid(ov4),
        .out_ready(or4), .product(p4), .busy(bz4)
    );

    seq_mult_hs #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .is_signed(s8), .out_valid(ov8),
        .out_ready(or8), .product(p8), .busy(bz8)
    );

    seq_mult_hs #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .is_signed(s16), .out_valid(ov16),
        .out_ready(or16), .product(p16), .busy(bz16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: interpret operands as integers, multiply, wrap to 2w bits.
    function automatic logic [31:0] ref_mul(input int w, input logic [15:0] av,
                                            input logic [15:0] bv, input logic sg);
        longint x;
        longint y;
        longint p;
        longint span;
        span = longint'(1) << w;
        x = longint'(av) & (span - 1);
        y = longint'(bv) & (span - 1);
        if (sg && x >= span / 2) x = x - span;
        if (sg && y >= span / 2) y = y - span;
        p = x * y;
        return 32'(p & ((longint'(1) << (2 * w)) - 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int w, input logic v, input logic [15:0] av,
                          input logic [15:0] bv, input logic sg);
        case (w)
            4: begin iv4 = v; a4 = av[3:0]; b4 = bv[3:0]; s4 = sg; end
            8: begin iv8 = v; a8 = av[7:0]; b8 = bv[7:0]; s8 = sg; end
            default: begin iv16 = v; a16 = av; b16 = bv; s16 = sg; end
        endcase
    endtask

    task automatic set_or(input int w, input logic v);
        case (w)
            4: or4 = v;
            8: or8 = v;
            default: or16 = v;
        endcase
    endtask

    function automatic logic f_ov(input int w);
        case (w)
            4: return ov4;
            8: return ov8;
            default: return ov16;
        endcase
    endfunction

    function automatic logic f_ir(input int w);
        case (w)
            4: return ir4;
            8: return ir8;
            default: return ir16;
        endcase
    endfunction

    function automatic logic f_bz(input int w);
        case (w)
            4: return bz4;
            8: return bz8;
            default: return bz16;
        endcase
    endfunction

    function automatic logic [31:0] f_p(input int w);
        case (w)
            4: return 32'(p4);
            8: return 32'(p8);
            default: return p16;
        endcase
    endfunction

    // One full transaction; hold = cycles of out_ready=0 while in DONE.
    task automatic run_op(input int w, input logic [15:0] av, input logic [15:0] bv,
                          input logic sg, input logic [31:0] exp, input int hold,
                          input string tag);
        int lat;
        set_or(w, hold == 0);
        chk({tag, "/idle_ready"}, 32'(f_ir(w)), 32'd1);
        set_in(w, 1'b1, av, bv, sg);
        @(negedge clk);
        set_in(w, 1'b0, 16'($urandom), 16'($urandom), ~sg);
        chk({tag, "/run_busy"}, 32'(f_bz(w)), 32'd1);
        chk({tag, "/run_ready"}, 32'(f_ir(w)), 32'd0);
        lat = 0;
        while (!f_ov(w) && lat < w + 4) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "/latency"}, 32'(lat), 32'(w));
        chk({tag, "/product"}, f_p(w), exp);
        for (int h = 0; h < hold; h++) begin
            set_in(w, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
            @(negedge clk);
            chk({tag, "/hold_valid"}, 32'(f_ov(w)), 32'd1);
            chk({tag, "/hold_ready"}, 32'(f_ir(w)), 32'd0);
            chk({tag, "/hold_product"}, f_p(w), exp);
        end
        set_in(w, 1'b0, 16'd0, 16'd0, 1'b0);
        set_or(w, 1'b1);
        @(negedge clk);
        chk({tag, "/ret_valid"}, 32'(f_ov(w)), 32'd0);
        chk({tag, "/ret_ready"}, 32'(f_ir(w)), 32'd1);
        chk({tag, "/ret_busy"}, 32'(f_bz(w)), 32'd0);
        chk({tag, "/ret_product"}, f_p(w), exp);
    endtask

    initial begin
        int ws[3];
        logic [15:0] av;
        logic [15:0] bv;
        logic [15:0] msk;
        logic sg;
        logic saw_ov;

        checks = 0;
        errors = 0;
        ws[0] = 8;
        ws[1] = 4;
        ws[2] = 16;

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(ws[i], 1'b0, 16'd0, 16'd0, 1'b0);
            set_or(ws[i], 1'b1);
        end
        repeat (2) @(negedge clk);
        chk("reset/in_ready", 32'(ir8), 32'd1);
        chk("reset/out_valid", 32'(ov8), 32'd0);
        chk("reset/busy", 32'(bz8), 32'd0);
        chk("reset/product", 32'(p8), 32'd0);
        chk("reset/product16", p16, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(8, 16'd13, 16'd11, 1'b0, 32'h008F, 0, "u13x11");
        run_op(8, 16'h80, 16'h80, 1'b1, 32'h4000, 0, "s_min_sq");
        run_op(8, 16'hFB, 16'h07, 1'b1, 32'hFFDD, 0, "s_m5x7");
        run_op(8, 16'hFF, 16'hFF, 1'b0, 32'hFE01, 0, "u255sq");
        run_op(8, 16'hFF, 16'hFF, 1'b1, 32'h0001, 0, "s_m1sq");
        run_op(8, 16'h00, 16'hF3, 1'b1, 32'h0000, 0, "s_zero");
        run_op(8, 16'd200, 16'd3, 1'b0, 32'h0258, 5, "backpressure");

        // Abort mid-run: reset lands on the edge of RUN iteration 3.
        set_in(8, 1'b1, 16'd100, 16'd100, 1'b0);
        @(negedge clk);
        set_in(8, 1'b0, 16'd0, 16'd0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort/in_ready", 32'(ir8), 32'd1);
        chk("abort/out_valid", 32'(ov8), 32'd0);
        chk("abort/busy", 32'(bz8), 32'd0);
        chk("abort/product", 32'(p8), 32'd0);
        saw_ov = 1'b0;
        repeat (10) begin
            @(negedge clk);
            saw_ov = saw_ov | ov8;
        end
        chk("abort/no_output", 32'(saw_ov), 32'd0);
        run_op(8, 16'd3, 16'd4, 1'b0, 32'd12, 0, "after_abort");

        run_op(4, 16'h8, 16'h8, 1'b1, 32'h40, 0, "w4_min_sq");
        run_op(16, 16'h8000, 16'h8000, 1'b1, 32'h4000_0000, 0, "w16_min_sq");

        for (int i = 0; i < 3; i++) begin
            msk = 16'((32'd1 << ws[i]) - 32'd1);
            repeat (20) begin
                av = 16'($urandom) & msk;
                bv = 16'($urandom) & msk;
                sg = 1'($urandom);
                run_op(ws[i], av, bv, sg, ref_mul(ws[i], av, bv, sg),
                       int'($urandom_range(0, 2)), "random");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
